dispense_seq: RTL and testbench

//  Sequences the coffee dispensing mechanism on behalf of the vend FSM.

---
 rtl/vend_pkg.sv | 42 ++++
 rtl/phase_timer.sv | 27 ++
 rtl/dispense_seq.sv | 157 +++++++++++++++
 tb/tb_dispense_seq.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/vend_pkg.sv
// Shared definitions for the vend datapath: sequencer state codes, coffee
// selection codes, flavour valve bit positions and small elaboration helpers.
package vend_pkg;

   localparam logic [3:0] ST_IDLE    = 4'd0;
   localparam logic [3:0] ST_HEAT    = 4'd1;
   localparam logic [3:0] ST_CUP     = 4'd2;
   localparam logic [3:0] ST_WATER   = 4'd3;
   localparam logic [3:0] ST_SHOT    = 4'd4;
   localparam logic [3:0] ST_STIR    = 4'd5;
   localparam logic [3:0] ST_DONE    = 4'd6;
   localparam logic [3:0] ST_RELEASE = 4'd7;
   localparam logic [3:0] ST_FAULT   = 4'd8;

   typedef enum logic [3:0] {
      S_IDLE    = ST_IDLE,
      S_HEAT    = ST_HEAT,
      S_CUP     = ST_CUP,
      S_WATER   = ST_WATER,
      S_SHOT    = ST_SHOT,
      S_STIR    = ST_STIR,
      S_DONE    = ST_DONE,
      S_RELEASE = ST_RELEASE,
      S_FAULT   = ST_FAULT
   } seq_state_t;

   localparam logic [2:0] SEL_PLAIN = 3'd1;
   localparam logic [2:0] SEL_HAZEL = 3'd2;
   localparam logic [2:0] SEL_COCO  = 3'd3;

   localparam int FLV_HAZEL = 0;
   localparam int FLV_COCO  = 1;

   function automatic logic sel_valid(input logic [2:0] sel);
      return (sel >= SEL_PLAIN) && (sel <= SEL_COCO);
   endfunction

   function automatic int max_of(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/phase_timer.sv
// Loadable down-counter with zero flag; saturates at zero so it never wraps.
// Load has priority over counting; one instance times every sequencer phase.
module phase_timer #(
   parameter int W = 6
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         zero
);

   logic [W-1:0] count;

   always_ff @(posedge clk) begin
      if (reset) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (count != '0) begin
         count <= count - 1'b1;
      end
   end

   assign zero = (count == '0);

endmodule

// File: rtl/dispense_seq.sv
// Coffee dispense sequencer: heater check, cup drop, water pour, optional flavour
// shot and (with DISPENSE_STIR_EN defined) a stir phase; Moore outputs from state.
module dispense_seq
   import vend_pkg::*;
#(
   parameter int CUP_CYCLES   = 4,
   parameter int WATER_CYCLES = 16,
   parameter int SHOT_CYCLES  = 8,
   parameter int STIR_CYCLES  = 6,
   parameter int HEAT_TIMEOUT = 64
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       dispense,
   input  logic [2:0] coffee_select,
   input  logic       heater_ready,
   output logic       dispense_done,
   output logic       seq_busy,
   output logic       cup_drop,
   output logic       water_valve,
   output logic [1:0] flavour_valve,
   output logic       stir_motor,
   output logic       fault
);

   localparam int MAX_CYC = max_of(max_of(max_of(CUP_CYCLES, WATER_CYCLES),
                                          max_of(SHOT_CYCLES, STIR_CYCLES)),
                                   HEAT_TIMEOUT);
   localparam int TW = $clog2(MAX_CYC);

   localparam logic [TW-1:0] HEAT_LD  = TW'(HEAT_TIMEOUT - 1);
   localparam logic [TW-1:0] CUP_LD   = TW'(CUP_CYCLES - 1);
   localparam logic [TW-1:0] WATER_LD = TW'(WATER_CYCLES - 1);
   localparam logic [TW-1:0] SHOT_LD  = TW'(SHOT_CYCLES - 1);
   localparam logic [TW-1:0] STIR_LD  = TW'(STIR_CYCLES - 1);

   // Where the sequence goes once the pour (and any flavour shot) is finished.
`ifdef DISPENSE_STIR_EN
   localparam seq_state_t POST_STATE = S_STIR;
   localparam logic       POST_LOAD  = 1'b1;
`else
   localparam seq_state_t POST_STATE = S_DONE;
   localparam logic       POST_LOAD  = 1'b0;
`endif

   seq_state_t    state, state_n;
   logic [2:0]    sel_q, sel_n;
   logic          tmr_load;
   logic [TW-1:0] tmr_val;
   logic          tmr_zero;

   phase_timer #(.W(TW)) u_timer (
      .clk      (clk),
      .reset    (reset),
      .load     (tmr_load),
      .load_val (tmr_val),
      .zero     (tmr_zero)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= S_IDLE;
         sel_q <= '0;
      end else begin
         state <= state_n;
         sel_q <= sel_n;
      end
   end

   always_comb begin
      state_n  = state;
      sel_n    = sel_q;
      tmr_load = 1'b0;
      tmr_val  = '0;
      unique case (state)
         S_IDLE: begin
            if (dispense) begin
               if (sel_valid(coffee_select)) begin
                  sel_n    = coffee_select;
                  state_n  = S_HEAT;
                  tmr_load = 1'b1;
                  tmr_val  = HEAT_LD;
               end else begin
                  state_n = S_FAULT;
               end
            end
         end
         S_HEAT: begin
            if (heater_ready) begin
               state_n  = S_CUP;
               tmr_load = 1'b1;
               tmr_val  = CUP_LD;
            end else if (tmr_zero) begin
               state_n = S_FAULT;
            end
         end
         S_CUP: begin
            if (tmr_zero) begin
               state_n  = S_WATER;
               tmr_load = 1'b1;
               tmr_val  = WATER_LD;
            end
         end
         S_WATER: begin
            if (tmr_zero) begin
               if (sel_q != SEL_PLAIN) begin
                  state_n  = S_SHOT;
                  tmr_load = 1'b1;
                  tmr_val  = SHOT_LD;
               end else begin
                  state_n  = POST_STATE;
                  tmr_load = POST_LOAD;
                  tmr_val  = STIR_LD;
               end
            end
         end
         S_SHOT: begin
            if (tmr_zero) begin
               state_n  = POST_STATE;
               tmr_load = POST_LOAD;
               tmr_val  = STIR_LD;
            end
         end
         S_STIR: begin
            if (tmr_zero) begin
               state_n = S_DONE;
            end
         end
         S_DONE:    state_n = S_RELEASE;
         // Hold here until vend drops the request so a held level cannot retrigger.
         S_RELEASE: if (!dispense) state_n = S_IDLE;
         S_FAULT:   state_n = S_FAULT;
         default:   state_n = S_FAULT;
      endcase
   end

   assign seq_busy      = (state != S_IDLE);
   assign cup_drop      = (state == S_CUP);
   assign water_valve   = (state == S_WATER);
   assign dispense_done = (state == S_DONE);
   assign fault         = (state == S_FAULT);

   always_comb begin
      flavour_valve = '0;
      if (state == S_SHOT) begin
         if (sel_q == SEL_HAZEL) flavour_valve[FLV_HAZEL] = 1'b1;
         else                    flavour_valve[FLV_COCO]  = 1'b1;
      end
   end

`ifdef DISPENSE_STIR_EN
   assign stir_motor = (state == S_STIR);
`else
   assign stir_motor = 1'b0;
`endif

endmodule

// File: tb/tb_dispense_seq.sv
// Self-checking bench for dispense_seq: per-drink expectations are queued at request
// time and compared when dispense_done appears; fault/reset paths checked directly.
module tb_dispense_seq;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       dispense = 1'b0;
   logic [2:0] coffee_select = 3'd0;
   logic       heater_ready = 1'b1;
   logic       dispense_done, seq_busy, cup_drop, water_valve, stir_motor, fault;
   logic [1:0] flavour_valve;

   int errors = 0;
   int checks = 0;

`ifdef DISPENSE_STIR_EN
   localparam int STIR_ADD = 6;
`else
   localparam int STIR_ADD = 0;
`endif

   typedef struct {
      int         lat;
      int         shot;
      int         stir;
      logic [1:0] flv;
   } exp_t;

   exp_t exp_q[$];

   dispense_seq dut (
      .clk           (clk),
      .reset         (reset),
      .dispense      (dispense),
      .coffee_select (coffee_select),
      .heater_ready  (heater_ready),
      .dispense_done (dispense_done),
      .seq_busy      (seq_busy),
      .cup_drop      (cup_drop),
      .water_valve   (water_valve),
      .flavour_valve (flavour_valve),
      .stir_motor    (stir_motor),
      .fault         (fault)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   function automatic logic [31:0] outs();
      return {24'd0, dispense_done, seq_busy, cup_drop, water_valve,
              flavour_valve, stir_motor, fault};
   endfunction

   function automatic logic actuators();
      return cup_drop | water_valve | (|flavour_valve) | stir_motor;
   endfunction

   task automatic run_drink(input logic [2:0] sel, input int hold);
      exp_t e, got;
      int   cup_n = 0, water_n = 0, shot_n = 0, stir_n = 0, done_n = 0;
      int   extra_done = 0, extra_act = 0;
      logic [1:0] flv_or = 2'b00;
      bit   seen = 0;
      e.shot = (sel != 3'd1) ? 8 : 0;
      e.stir = STIR_ADD;
      e.lat  = 2 + 4 + 16 + e.shot + e.stir;
      e.flv  = (sel == 3'd2) ? 2'b01 : (sel == 3'd3) ? 2'b10 : 2'b00;
      exp_q.push_back(e);

      @(negedge clk);
      dispense      = 1'b1;
      coffee_select = sel;
      for (int k = 1; k <= 80 && !seen; k++) begin
         @(posedge clk); #1;
         if (k == 1) coffee_select = 3'd7;  // must be ignored after accept
         if (cup_drop)    cup_n++;
         if (water_valve) water_n++;
         if (|flavour_valve) shot_n++;
         if (stir_motor)  stir_n++;
         flv_or |= flavour_valve;
         if (dispense_done) begin
            seen = 1;
            done_n++;
            got = exp_q.pop_front();
            check($sformatf("lat_sel%0d", sel), k, got.lat);
            check($sformatf("cup_sel%0d", sel), cup_n, 4);
            check($sformatf("water_sel%0d", sel), water_n, 16);
            check($sformatf("shot_sel%0d", sel), shot_n, got.shot);
            check($sformatf("flv_sel%0d", sel), {30'd0, flv_or}, {30'd0, got.flv});
            check($sformatf("stir_sel%0d", sel), stir_n, got.stir);
         end
      end
      if (!seen) begin
         check($sformatf("done_timeout_sel%0d", sel), 0, 1);
         void'(exp_q.pop_front());
      end

      for (int k = 0; k < hold; k++) begin
         @(posedge clk); #1;
         if (dispense_done) extra_done++;
         if (actuators())   extra_act++;
      end
      if (hold > 0) begin
         check("hold_done", extra_done, 0);
         check("hold_act", extra_act, 0);
         check("hold_busy", seq_busy, 1);
      end
      @(negedge clk);
      dispense = 1'b0;
      repeat (2) @(posedge clk);
      #1 check($sformatf("idle_after_sel%0d", sel), seq_busy, 0);
   endtask

   task automatic apply_reset();
      @(negedge clk);
      reset    = 1'b1;
      dispense = 1'b0;
      @(posedge clk); #1;
      check("reset_outs", outs(), 0);
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic bad_sel(input logic [2:0] sel);
      int cup_n = 0;
      @(negedge clk);
      dispense      = 1'b1;
      coffee_select = sel;
      @(posedge clk); #1;
      check($sformatf("bad_sel%0d_fault", sel), fault, 1);
      for (int k = 0; k < 5; k++) begin
         @(posedge clk); #1;
         if (cup_drop) cup_n++;
      end
      check($sformatf("bad_sel%0d_cup", sel), cup_n, 0);
      apply_reset();
   endtask

   initial begin
      int act_n, done_n;
      repeat (2) @(posedge clk);
      #1 check("reset_state", outs(), 0);
      @(negedge clk);
      reset = 1'b0;

      run_drink(3'd1, 0);
      run_drink(3'd2, 0);
      run_drink(3'd3, 0);

      // Heater never ready: timeout into FAULT, then reset clears it.
      act_n = 0;
      done_n = 0;
      @(negedge clk);
      heater_ready  = 1'b0;
      dispense      = 1'b1;
      coffee_select = 3'd2;
      for (int k = 1; k <= 70; k++) begin
         @(posedge clk); #1;
         if (actuators())   act_n++;
         if (dispense_done) done_n++;
         if (k == 64) check("heat_fault_early", fault, 0);
         if (k == 65) check("heat_fault", fault, 1);
      end
      check("heat_act", act_n, 0);
      check("heat_done", done_n, 0);
      apply_reset();
      check("heat_cleared", fault, 0);
      heater_ready = 1'b1;

      bad_sel(3'd0);
      bad_sel(3'd5);

      run_drink(3'd2, 10);
      run_drink(3'd3, 0);

      // Reset while pouring water.
      @(negedge clk);
      dispense      = 1'b1;
      coffee_select = 3'd3;
      repeat (10) @(posedge clk);
      #1 check("mid_water", water_valve, 1);
      apply_reset();
      run_drink(3'd1, 0);

      check("queue_empty", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
